// File: rtl/posted_target_pkg.sv
// Shared types and constants for the posted-write bus target.
package posted_target_pkg;

    localparam int IDX_BITS_DFLT = 11;

    typedef enum logic [2:0] {
        IDLE,
        WR_DATA,
        WR_ACK,
        RD_LOOKUP,
        RD_DATA
    } state_t;

    typedef struct packed {
        logic [IDX_BITS_DFLT-1:0] idx;
        logic [7:0]               data;
    } queue_entry_t;

    localparam logic RW_WRITE = 1'b1;
    localparam logic RW_READ  = 1'b0;

endpackage

// File: rtl/posted_write_target_write_queue.sv
// Circular posted-write FIFO with a combinational youngest-match search port.
module write_queue
    import posted_target_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int IDX_W = IDX_BITS_DFLT,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [IDX_W-1:0] push_idx_i,
    input  logic [7:0]       push_data_i,
    input  logic             pop_i,
    output logic [IDX_W-1:0] head_idx_o,
    output logic [7:0]       head_data_o,
    output logic [CNT_W-1:0] count_o,
    input  logic [IDX_W-1:0] search_idx_i,
    output logic             hit_o,
    output logic [7:0]       hit_data_o
);

    typedef struct packed {
        logic [IDX_W-1:0] idx;
        logic [7:0]       data;
    } entry_t;

    entry_t           entry_q [DEPTH];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [PTR_W-1:0] srch_ptr;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (push_i) tail_d = tail_q + 1'b1;
        if (pop_i)  head_d = head_q + 1'b1;
        case ({push_i, pop_i})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_i) entry_q[tail_q] <= '{idx: push_idx_i, data: push_data_i};
    end

    // Walk entries oldest to youngest so the youngest match overrides.
    always_comb begin
        hit_o      = 1'b0;
        hit_data_o = '0;
        srch_ptr   = head_q;
        for (int k = 0; k < DEPTH; k++) begin
            srch_ptr = head_q + PTR_W'(k);
            if ((CNT_W'(k) < count_q) && (entry_q[srch_ptr].idx == search_idx_i)) begin
                hit_o      = 1'b1;
                hit_data_o = entry_q[srch_ptr].data;
            end
        end
    end

    assign head_idx_o  = entry_q[head_q].idx;
    assign head_data_o = entry_q[head_q].data;
    assign count_o     = count_q;

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(push_i && !pop_i && (count_q == CNT_W'(DEPTH))));
    a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(pop_i && (count_q == '0)));
    a_count_range: assert property (@(posedge clk) disable iff (!rst_n)
        count_q <= CNT_W'(DEPTH));

endmodule

// File: rtl/posted_write_target.sv
// Bus target that acks writes at once, posts them to a queue drained into local memory.
module posted_write_target
    import posted_target_pkg::*;
#(
    parameter int INTERNAL_ADDR_BITS = 11,
    parameter int QUEUE_DEPTH        = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [15:0]                    target_addr_in,
    input  logic                           target_addr_in_valid,
    input  logic [7:0]                     target_data_in,
    input  logic                           target_data_in_valid,
    input  logic                           target_rw,
    input  logic                           mem_drain_en,
    output logic [7:0]                     target_data_out,
    output logic                           target_data_out_valid,
    output logic                           target_ack,
    output logic                           target_ready,
    output logic [$clog2(QUEUE_DEPTH):0]   queue_count,
    output logic                           queue_empty
);

    localparam int IAB   = INTERNAL_ADDR_BITS;
    localparam int CNT_W = $clog2(QUEUE_DEPTH) + 1;

    state_t           state_q, state_d;
    logic [IAB-1:0]   idx_q, idx_d;
    logic [7:0]       wdata_q, wdata_d;
    logic             hit_q;
    logic [7:0]       fwd_q;
    logic [7:0]       mem_rd_q;
    logic [7:0]       dout_q;
    logic [7:0]       rd_data;
    logic [7:0]       mem [2**IAB];

    logic             q_push, q_pop, q_hit;
    logic [IAB-1:0]   q_head_idx;
    logic [7:0]       q_head_data, q_hit_data;
    logic [CNT_W-1:0] q_count;

    // Upper address bits alias onto the same memory locations.
    logic unused_addr_hi;
    assign unused_addr_hi = ^target_addr_in[15:IAB];

    write_queue #(
        .DEPTH (QUEUE_DEPTH),
        .IDX_W (IAB)
    ) u_queue (
        .clk          (clk),
        .rst_n        (rst_n),
        .push_i       (q_push),
        .push_idx_i   (idx_q),
        .push_data_i  (wdata_q),
        .pop_i        (q_pop),
        .head_idx_o   (q_head_idx),
        .head_data_o  (q_head_data),
        .count_o      (q_count),
        .search_idx_i (idx_q),
        .hit_o        (q_hit),
        .hit_data_o   (q_hit_data)
    );

    assign target_ready = (state_q == IDLE) && (q_count < CNT_W'(QUEUE_DEPTH));
    assign q_push       = (state_q == WR_ACK);
    // The read owns the memory port during lookup, so draining pauses then.
    assign q_pop        = mem_drain_en && (q_count != '0) && (state_q != RD_LOOKUP);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        case (state_q)
            IDLE: begin
                if (target_addr_in_valid && target_ready) begin
                    idx_d = target_addr_in[IAB-1:0];
                    if (target_rw == RW_WRITE) begin
                        if (target_data_in_valid) begin
                            wdata_d = target_data_in;
                            state_d = WR_ACK;
                        end else begin
                            state_d = WR_DATA;
                        end
                    end else begin
                        state_d = RD_LOOKUP;
                    end
                end
            end
            WR_DATA: begin
                if (target_data_in_valid) begin
                    wdata_d = target_data_in;
                    state_d = WR_ACK;
                end
            end
            WR_ACK:    state_d = IDLE;
            RD_LOOKUP: state_d = RD_DATA;
            RD_DATA:   state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            dout_q  <= 8'h00;
        end else begin
            state_q <= state_d;
            if (state_q == RD_DATA) dout_q <= rd_data;
        end
    end

    always_ff @(posedge clk) begin
        idx_q   <= idx_d;
        wdata_q <= wdata_d;
        if (state_q == RD_LOOKUP) begin
            hit_q <= q_hit;
            fwd_q <= q_hit_data;
        end
    end

    always_ff @(posedge clk) begin
        if (q_pop) mem[q_head_idx] <= q_head_data;
        if (state_q == RD_LOOKUP) mem_rd_q <= mem[idx_q];
    end

    assign rd_data               = hit_q ? fwd_q : mem_rd_q;
    assign target_data_out       = (state_q == RD_DATA) ? rd_data : dout_q;
    assign target_data_out_valid = (state_q == RD_DATA);
    assign target_ack            = (state_q == WR_ACK) || (state_q == RD_DATA);
    assign queue_count           = q_count;
    assign queue_empty           = (q_count == '0);

endmodule

// File: tb/tb_posted_write_target.sv
// Randomized bench for posted_write_target against a flat memory reference model.
module tb_posted_write_target;

    localparam int IAB = 11;
    localparam int QD  = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] target_addr_in;
    logic        target_addr_in_valid;
    logic [7:0]  target_data_in;
    logic        target_data_in_valid;
    logic        target_rw;
    logic        mem_drain_en;
    logic [7:0]  target_data_out;
    logic        target_data_out_valid;
    logic        target_ack;
    logic        target_ready;
    logic [2:0]  queue_count;
    logic        queue_empty;

    logic [7:0]  mem_m [2**IAB];
    int          n_chk = 0;
    int          n_pass = 0;

    posted_write_target #(
        .INTERNAL_ADDR_BITS (IAB),
        .QUEUE_DEPTH        (QD)
    ) dut (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .target_addr_in        (target_addr_in),
        .target_addr_in_valid  (target_addr_in_valid),
        .target_data_in        (target_data_in),
        .target_data_in_valid  (target_data_in_valid),
        .target_rw             (target_rw),
        .mem_drain_en          (mem_drain_en),
        .target_data_out       (target_data_out),
        .target_data_out_valid (target_data_out_valid),
        .target_ack            (target_ack),
        .target_ready          (target_ready),
        .queue_count           (queue_count),
        .queue_empty           (queue_empty)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!target_ready && n < 100) begin
            if (n > 3) mem_drain_en = 1'b1;
            step();
            n++;
        end
        chk("ready_wait", target_ready, 1'b1);
    endtask

    task automatic wait_empty();
        int n = 0;
        while (!queue_empty && n < 100) begin
            step();
            n++;
        end
        chk("empty_wait", queue_empty, 1'b1);
    endtask

    // Address at cycle T, data at T+k; ack expected at T+k+1 only.
    task automatic do_write(input logic [15:0] addr, input logic [7:0] data, input int k);
        wait_ready();
        target_addr_in       = addr;
        target_rw            = 1'b1;
        target_addr_in_valid = 1'b1;
        target_data_in       = (k == 0) ? data : ~data;
        target_data_in_valid = (k == 0);
        step();
        target_addr_in_valid = 1'b0;
        target_data_in_valid = 1'b0;
        if (k > 0) begin
            for (int i = 1; i < k; i++) begin
                chk("wr_ack_early", target_ack, 1'b0);
                target_addr_in       = 16'($urandom);
                target_rw            = 1'($urandom);
                target_addr_in_valid = 1'($urandom);
                step();
            end
            chk("wr_ack_early", target_ack, 1'b0);
            target_addr_in_valid = 1'b0;
            target_data_in       = data;
            target_data_in_valid = 1'b1;
            step();
            target_data_in_valid = 1'b0;
        end
        chk("wr_ack", target_ack, 1'b1);
        chk("wr_no_rdvalid", target_data_out_valid, 1'b0);
        mem_m[addr[IAB-1:0]] = data;
    endtask

    task automatic do_read(input logic [15:0] addr, input logic [7:0] exp);
        wait_ready();
        target_addr_in       = addr;
        target_rw            = 1'b0;
        target_addr_in_valid = 1'b1;
        step();
        target_addr_in_valid = 1'b0;
        chk("rd_ack_early", target_ack, 1'b0);
        chk("rd_valid_early", target_data_out_valid, 1'b0);
        step();
        chk("rd_valid", target_data_out_valid, 1'b1);
        chk("rd_ack", target_ack, 1'b1);
        chk("rd_data", target_data_out, exp);
        step();
        chk("rd_valid_pulse", target_data_out_valid, 1'b0);
        chk("rd_ack_pulse", target_ack, 1'b0);
        chk("rd_data_hold", target_data_out, exp);
    endtask

    initial begin
        logic [15:0] a;
        logic [7:0]  old;
        logic [4:0]  hi;
        logic [2:0]  lo;

        for (int i = 0; i < 2**IAB; i++) mem_m[i] = 8'h00;
        rst_n                = 1'b0;
        target_addr_in       = '0;
        target_addr_in_valid = 1'b0;
        target_data_in       = '0;
        target_data_in_valid = 1'b0;
        target_rw            = 1'b0;
        mem_drain_en         = 1'b0;
        step();
        step();
        chk("rst_ack", target_ack, 1'b0);
        chk("rst_rdvalid", target_data_out_valid, 1'b0);
        chk("rst_dout", target_data_out, 8'h00);
        chk("rst_count", queue_count, 3'd0);
        chk("rst_empty", queue_empty, 1'b1);
        chk("rst_ready", target_ready, 1'b1);
        rst_n = 1'b1;
        step();

        // Basic write then read back
        mem_drain_en = 1'b0;
        do_write(16'h4004, 8'hA7, 0);
        chk("basic_cnt_at_ack", queue_count, 3'd0);
        step();
        chk("basic_cnt_posted", queue_count, 3'd1);
        chk("basic_ack_pulse", target_ack, 1'b0);
        mem_drain_en = 1'b1;
        step();
        chk("basic_cnt_drained", queue_count, 3'd0);
        chk("basic_empty", queue_empty, 1'b1);
        do_read(16'h4004, 8'hA7);

        // Forwarding of the youngest pending write
        mem_drain_en = 1'b0;
        do_write(16'h0020, 8'h33, 0);
        do_write(16'h0020, 8'h44, 0);
        step();
        chk("fwd_cnt", queue_count, 3'd2);
        do_read(16'h0020, 8'h44);
        mem_drain_en = 1'b1;
        wait_empty();
        do_read(16'h0020, 8'h44);

        // Full queue
        mem_drain_en = 1'b0;
        for (int i = 1; i <= 4; i++) do_write(16'(i), 8'(8'h10 + i), 0);
        step();
        chk("full_cnt", queue_count, 3'd4);
        chk("full_ready", target_ready, 1'b0);
        target_addr_in       = 16'h0005;
        target_rw            = 1'b1;
        target_data_in       = 8'hEE;
        target_addr_in_valid = 1'b1;
        target_data_in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("full_noack", target_ack, 1'b0);
            chk("full_cnt_hold", queue_count, 3'd4);
        end
        target_addr_in_valid = 1'b0;
        target_data_in_valid = 1'b0;
        mem_drain_en = 1'b1;
        step();
        mem_drain_en = 1'b0;
        chk("full_cnt_pop", queue_count, 3'd3);
        chk("full_ready_back", target_ready, 1'b1);
        mem_drain_en = 1'b1;
        wait_empty();
        do_read(16'h0005, mem_m[5]);
        do_read(16'h0003, 8'h13);

        // Split address/data phases with aliasing
        mem_drain_en = 1'b0;
        do_write(16'h8004, 8'h5E, 3);
        do_read(16'h0004, 8'h5E);

        // Reset with a write still in flight
        mem_drain_en = 1'b1;
        wait_empty();
        mem_drain_en = 1'b0;
        old = mem_m[16];
        do_write(16'h0010, 8'hAA, 0);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_ack", target_ack, 1'b0);
        chk("mid_rst_cnt", queue_count, 3'd0);
        chk("mid_rst_empty", queue_empty, 1'b1);
        mem_m[16] = old;
        step();
        rst_n = 1'b1;
        step();
        do_read(16'h0010, old);

        // Random traffic over a few aliased indices
        for (int t = 0; t < 200; t++) begin
            mem_drain_en = 1'($urandom);
            hi = 5'($urandom);
            lo = 3'($urandom);
            a  = {hi, 8'h00, lo};
            if ($urandom_range(0, 1) == 1) do_write(a, 8'($urandom), $urandom_range(0, 2));
            else                           do_read(a, mem_m[a[IAB-1:0]]);
            chk("rand_empty_flag", queue_empty, (queue_count == 3'd0));
            chk("rand_cnt_range", (queue_count <= 3'd4), 1'b1);
        end

        mem_drain_en = 1'b1;
        wait_empty();
        for (int i = 0; i < 8; i++) do_read(16'(i), mem_m[i]);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
